// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus timing generator:
// FSM state encoding, default strobe timings and the address/data phase flag.
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_ADDR_SETUP = 4'd1,
        ST_ADDR_PULSE = 4'd2,
        ST_ADDR_HOLD  = 4'd3,
        ST_GAP        = 4'd4,
        ST_DATA_SETUP = 4'd5,
        ST_DATA_PULSE = 4'd6,
        ST_DATA_HOLD  = 4'd7,
        ST_DONE       = 4'd8
    } rtc_state_e;

    localparam int RTC_T_SETUP = 2;
    localparam int RTC_T_PULSE = 10;
    localparam int RTC_T_HOLD  = 2;
    localparam int RTC_T_GAP   = 4;

    localparam logic PHASE_ADDR = 1'b0;
    localparam logic PHASE_DATA = 1'b1;

    // Bus content flag: the gap already belongs to the data phase so the
    // bus driver can turn the bus around while CS is high.
    function automatic logic phase_of(rtc_state_e s);
        case (s)
            ST_GAP, ST_DATA_SETUP, ST_DATA_PULSE, ST_DATA_HOLD: phase_of = PHASE_DATA;
            default:                                            phase_of = PHASE_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_timing_generator_timer.sv
// Loadable down-counter that times each bus phase; o_zero marks the last
// cycle of the current phase.
module rtc_phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/rtc_bus_timing_generator.sv
// Intel-style multiplexed-bus strobe generator for the external RTC chip:
// one address phase, optional CS-high gap, one data phase, then a done pulse.
module rtc_bus_timing_generator
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = RTC_T_SETUP,
    parameter int T_PULSE = RTC_T_PULSE,
    parameter int T_HOLD  = RTC_T_HOLD,
    parameter int T_GAP   = RTC_T_GAP,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic en_funcion,
    input  logic in_escribir_leer,
    output logic reg_a_d,
    output logic reg_cs,
    output logic reg_wr,
    output logic reg_rd,
    output logic out_direccion_dato,
    output logic flag_done,
    output logic busy
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'((T_GAP > 0) ? (T_GAP - 1) : 0);

    rtc_state_e       r_state;
    rtc_state_e       w_next_state;
    logic             r_en_q;
    logic             r_wr_mode;
    logic             w_start;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_zero;

    logic r_a_d, r_cs, r_wr, r_rd, r_dir, r_done, r_busy;
    logic w_a_d, w_cs, w_wr, w_rd, w_dir, w_done, w_busy;

    // Only a fresh rising edge seen while idle starts a transaction; edges
    // during a transaction are dropped, not queued.
    assign w_start = en_funcion & ~r_en_q & (r_state == ST_IDLE);

    rtc_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .i_dec     (w_dec),
        .o_zero    (w_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_en_q    <= 1'b0;
            r_wr_mode <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_en_q  <= en_funcion;
            if (w_start) begin
                r_wr_mode <= in_escribir_leer;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_dec        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_ADDR_SETUP;
                    w_load       = 1'b1;
                    w_load_val   = LD_SETUP;
                end
            end
            ST_ADDR_SETUP: begin
                if (w_zero) begin
                    w_next_state = ST_ADDR_PULSE;
                    w_load       = 1'b1;
                    w_load_val   = LD_PULSE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_ADDR_PULSE: begin
                if (w_zero) begin
                    w_next_state = ST_ADDR_HOLD;
                    w_load       = 1'b1;
                    w_load_val   = LD_HOLD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_ADDR_HOLD: begin
                if (w_zero) begin
                    w_load = 1'b1;
                    if (T_GAP > 0) begin
                        w_next_state = ST_GAP;
                        w_load_val   = LD_GAP;
                    end else begin
                        w_next_state = ST_DATA_SETUP;
                        w_load_val   = LD_SETUP;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_zero) begin
                    w_next_state = ST_DATA_SETUP;
                    w_load       = 1'b1;
                    w_load_val   = LD_SETUP;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_DATA_SETUP: begin
                if (w_zero) begin
                    w_next_state = ST_DATA_PULSE;
                    w_load       = 1'b1;
                    w_load_val   = LD_PULSE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_DATA_PULSE: begin
                if (w_zero) begin
                    w_next_state = ST_DATA_HOLD;
                    w_load       = 1'b1;
                    w_load_val   = LD_HOLD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_DATA_HOLD: begin
                if (w_zero) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin changes on the
    // same edge as the state it belongs to, with no extra cycle of lag.
    always_comb begin
        w_a_d  = PHASE_DATA;
        w_cs   = 1'b1;
        w_wr   = 1'b1;
        w_rd   = 1'b1;
        w_dir  = phase_of(w_next_state);
        w_done = 1'b0;
        w_busy = (w_next_state != ST_IDLE);
        case (w_next_state)
            ST_ADDR_SETUP, ST_ADDR_HOLD: begin
                w_a_d = PHASE_ADDR;
                w_cs  = 1'b0;
            end
            ST_ADDR_PULSE: begin
                w_a_d = PHASE_ADDR;
                w_cs  = 1'b0;
                w_wr  = 1'b0;
            end
            ST_DATA_SETUP, ST_DATA_HOLD: begin
                w_cs = 1'b0;
            end
            ST_DATA_PULSE: begin
                w_cs = 1'b0;
                if (r_wr_mode) begin
                    w_wr = 1'b0;
                end else begin
                    w_rd = 1'b0;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_d  <= 1'b1;
            r_cs   <= 1'b1;
            r_wr   <= 1'b1;
            r_rd   <= 1'b1;
            r_dir  <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_a_d  <= w_a_d;
            r_cs   <= w_cs;
            r_wr   <= w_wr;
            r_rd   <= w_rd;
            r_dir  <= w_dir;
            r_done <= w_done;
            r_busy <= w_busy;
        end
    end

    assign reg_a_d            = r_a_d;
    assign reg_cs             = r_cs;
    assign reg_wr             = r_wr;
    assign reg_rd             = r_rd;
    assign out_direccion_dato = r_dir;
    assign flag_done          = r_done;
    assign busy               = r_busy;

endmodule

// File: tb/tb_rtc_bus_timing_generator.sv
// Testbench for rtc_bus_timing_generator: a default-timing instance and a
// T_GAP=0/T_PULSE=1 instance driven together and compared against a waveform model.
module tb_rtc_bus_timing_generator;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic en    = 1'b0;
    logic mode  = 1'b0;

    logic aAd, aCs, aWr, aRd, aDir, aDone, aBusy;
    logic bAd, bCs, bWr, bRd, bDir, bDone, bBusy;
    logic [6:0] obsA, obsB;

    // Output vector order: {a_d, cs, wr, rd, dir, done, busy}
    localparam logic [6:0] V_IDLE   = 7'b1111000;
    localparam logic [6:0] V_ASET   = 7'b0011001;
    localparam logic [6:0] V_APUL   = 7'b0001001;
    localparam logic [6:0] V_GAP    = 7'b1111101;
    localparam logic [6:0] V_DSET   = 7'b1011101;
    localparam logic [6:0] V_DPUL_W = 7'b1001101;
    localparam logic [6:0] V_DPUL_R = 7'b1010101;
    localparam logic [6:0] V_DONE   = 7'b1111011;

    localparam int A_TS = 2, A_TP = 10, A_TH = 2, A_TG = 4;
    localparam int B_TS = 2, B_TP = 1,  B_TH = 2, B_TG = 0;
    localparam int LEN_A = 2 * (A_TS + A_TP + A_TH) + A_TG + 2;
    localparam int LEN_B = 2 * (B_TS + B_TP + B_TH) + B_TG + 2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int posA = -1;
    int posB = -1;
    bit modeA = 1'b0;
    bit modeB = 1'b0;
    bit prevEn = 1'b0;
    int doneCntA, doneCntB, firstCsA, doneCycA, firstCsB, doneCycB;

    rtc_bus_timing_generator dutA (
        .clk(clk), .reset(reset), .en_funcion(en), .in_escribir_leer(mode),
        .reg_a_d(aAd), .reg_cs(aCs), .reg_wr(aWr), .reg_rd(aRd),
        .out_direccion_dato(aDir), .flag_done(aDone), .busy(aBusy)
    );

    rtc_bus_timing_generator #(.T_GAP(0), .T_PULSE(1)) dutB (
        .clk(clk), .reset(reset), .en_funcion(en), .in_escribir_leer(mode),
        .reg_a_d(bAd), .reg_cs(bCs), .reg_wr(bWr), .reg_rd(bRd),
        .out_direccion_dato(bDir), .flag_done(bDone), .busy(bBusy)
    );

    assign obsA = {aAd, aCs, aWr, aRd, aDir, aDone, aBusy};
    assign obsB = {bAd, bCs, bWr, bRd, bDir, bDone, bBusy};

    always #5 clk = ~clk;

    // Expected pins for cycle n of a transaction, walking the phase list;
    // the final entry is the idle cycle while the FSM leaves DONE.
    function automatic logic [6:0] txnVec(int n, bit wrMode, int ts, int tp, int th, int tg);
        int k;
        k = n;
        if (k < ts) return V_ASET;
        k -= ts;
        if (k < tp) return V_APUL;
        k -= tp;
        if (k < th) return V_ASET;
        k -= th;
        if (k < tg) return V_GAP;
        k -= tg;
        if (k < ts) return V_DSET;
        k -= ts;
        if (k < tp) return wrMode ? V_DPUL_W : V_DPUL_R;
        k -= tp;
        if (k < th) return V_DSET;
        k -= th;
        if (k == 0) return V_DONE;
        return V_IDLE;
    endfunction

    function automatic logic [6:0] expA();
        return (posA < 0) ? V_IDLE : txnVec(posA, modeA, A_TS, A_TP, A_TH, A_TG);
    endfunction

    function automatic logic [6:0] expB();
        return (posB < 0) ? V_IDLE : txnVec(posB, modeB, B_TS, B_TP, B_TH, B_TG);
    endfunction

    task automatic modelUpdate();
        if (!reset) begin
            posA   = -1;
            posB   = -1;
            prevEn = 1'b0;
        end else begin
            if (posA >= 0) begin
                posA++;
                if (posA == LEN_A) posA = -1;
            end
            if (posB >= 0) begin
                posB++;
                if (posB == LEN_B) posB = -1;
            end
            if (en && !prevEn) begin
                if (posA < 0) begin
                    posA  = 0;
                    modeA = mode;
                end
                if (posB < 0) begin
                    posB  = 0;
                    modeB = mode;
                end
            end
            prevEn = en;
        end
    endtask

    task automatic checkOutput(string tag, logic [6:0] observed, logic [6:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        cyc++;
        modelUpdate();
        #2;
        checkOutput("dutA", obsA, expA());
        checkOutput("dutB", obsB, expB());
        if (aDone) doneCntA++;
        if (bDone) doneCntB++;
        if (firstCsA < 0 && !aCs) firstCsA = cyc;
        if (doneCycA < 0 && aDone) doneCycA = cyc;
        if (firstCsB < 0 && !bCs) firstCsB = cyc;
        if (doneCycB < 0 && bDone) doneCycB = cyc;
    endtask

    task automatic applyStimulus(bit e, bit m, int n);
        en   = e;
        mode = m;
        repeat (n) stepCycle();
    endtask

    task automatic clearTrack();
        doneCntA = 0;
        doneCntB = 0;
        firstCsA = -1;
        doneCycA = -1;
        firstCsB = -1;
        doneCycB = -1;
    endtask

    initial begin
        int w;
        clearTrack();

        // Reset held, then idle with enable low
        applyStimulus(1'b0, 1'b0, 5);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 20);

        // Write transaction with default timing
        clearTrack();
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 40);
        checks++;
        assert (doneCycA - firstCsA === 32) else begin
            errors++;
            $error("FAIL writeLatencyA: observed %0d expected 32", doneCycA - firstCsA);
        end
        checks++;
        assert (doneCycB - firstCsB === 10) else begin
            errors++;
            $error("FAIL writeLatencyB: observed %0d expected 10", doneCycB - firstCsB);
        end

        // Read transaction with default timing
        clearTrack();
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 40);
        checks++;
        assert (doneCntA === 1) else begin
            errors++;
            $error("FAIL readDoneCountA: observed %0d expected 1", doneCntA);
        end

        // Enable held high for 100 cycles gives a single transaction
        clearTrack();
        applyStimulus(1'b1, 1'b1, 100);
        checks++;
        assert (doneCntA === 1 && doneCntB === 1) else begin
            errors++;
            $error("FAIL heldEnable: observed A=%0d B=%0d expected 1", doneCntA, doneCntB);
        end
        applyStimulus(1'b0, 1'b1, 5);

        // Enable and mode toggled mid-transaction are ignored
        applyStimulus(1'b1, 1'b0, 1);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'(i % 2), 1'(~i[1]), 1);
        end
        applyStimulus(1'b0, 1'b0, 10);

        // Asynchronous reset during the data strobe
        applyStimulus(1'b1, 1'b1, 1);
        w = 0;
        while (posA != 24 && w < 60) begin
            stepCycle();
            w++;
        end
        checks++;
        assert (w < 60 && aWr === 1'b0) else begin
            errors++;
            $error("FAIL midPulseWr: observed wr=%b wait=%0d expected wr=0", aWr, w);
        end
        #1 reset = 1'b0;
        #1;
        checkOutput("asyncRstA", obsA, V_IDLE);
        checkOutput("asyncRstB", obsB, V_IDLE);
        applyStimulus(1'b0, 1'b1, 3);
        reset = 1'b1;
        clearTrack();
        applyStimulus(1'b0, 1'b1, 40);
        checks++;
        assert (doneCntA === 0) else begin
            errors++;
            $error("FAIL noDoneAfterReset: observed %0d expected 0", doneCntA);
        end

        // Enable still high at reset release starts a transaction
        applyStimulus(1'b1, 1'b0, 2);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 2);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 40);
        applyStimulus(1'b0, 1'b0, 3);

        // Randomized enable and mode activity
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) en = ~en;
            mode = 1'($urandom_range(0, 1));
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
